// File: rtl/conv_seq_fsm_pkg.sv
// Shared definitions for the convolution frame sequencer: default geometry and FSM state encoding.
package conv_seq_fsm_pkg;

    localparam int NB_ADDRESS_DEF = 10;
    localparam int W_LAT_DEF      = 3;
    localparam int K_ROWS_DEF     = 3;
    localparam int N_BLOCKS_DEF   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KLOAD = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_CHBLK = 3'd4
    } state_e;

endpackage

// File: rtl/conv_seq_fsm_gpio_edge_sync.sv
// Brings one asynchronous GPIO level into the clock domain and flags its rising edge.
module conv_seq_fsm_gpio_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/conv_seq_fsm.sv
// Frame sequencer: turns GPIO commands into kernel-load, block-sweep and block-change
// sequences driving the MCU address/control lines and the Conv lane strobes.
module conv_seq_fsm
    import conv_seq_fsm_pkg::*;
#(
    parameter int NB_ADDRESS = NB_ADDRESS_DEF,
    parameter int W_LAT      = W_LAT_DEF,
    parameter int K_ROWS     = K_ROWS_DEF,
    parameter int N_BLOCKS   = N_BLOCKS_DEF
) (
    input  logic                          CLK100MHZ,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_load_k,
    input  logic                          i_next,
    input  logic [NB_ADDRESS-1:0]         i_last_addr,
    output logic                          o_sop,
    output logic                          o_eop,
    output logic                          o_chblk,
    output logic                          o_valid,
    output logic                          o_ki,
    output logic [NB_ADDRESS-1:0]         o_raddr,
    output logic [NB_ADDRESS-1:0]         o_waddr,
    output logic [$clog2(N_BLOCKS)-1:0]   o_blk,
    output logic                          o_frame_done
);

    localparam int BLK_W = $clog2(N_BLOCKS);
    // Sweep cycle counter must reach last_addr + W_LAT without wrapping.
    localparam int CNT_W = NB_ADDRESS + 2;

    localparam logic [NB_ADDRESS-1:0] ADDR_ONE = NB_ADDRESS'(1);
    localparam logic [NB_ADDRESS-1:0] K_LAST   = NB_ADDRESS'(K_ROWS - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAT  = CNT_W'(W_LAT);
    localparam logic [BLK_W-1:0]      BLK_ONE  = BLK_W'(1);
    localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(N_BLOCKS - 1);

    logic start_rise_s;
    logic load_k_rise_s;
    logic next_rise_s;
    logic [CNT_W-1:0] drain_end_s;

    state_e                state_q;
    logic                  sop_q;
    logic                  eop_q;
    logic                  chblk_q;
    logic                  valid_q;
    logic                  ki_q;
    logic [NB_ADDRESS-1:0] raddr_q;
    logic [NB_ADDRESS-1:0] waddr_q;
    logic [BLK_W-1:0]      blk_q;
    logic                  frame_done_q;
    logic [NB_ADDRESS-1:0] last_q;
    logic [CNT_W-1:0]      cnt_q;

    conv_seq_fsm_gpio_edge_sync u_sync_start (
        .clk_i  (CLK100MHZ),
        .rst_ni (i_reset),
        .pin_i  (i_start),
        .rise_o (start_rise_s)
    );

    conv_seq_fsm_gpio_edge_sync u_sync_load_k (
        .clk_i  (CLK100MHZ),
        .rst_ni (i_reset),
        .pin_i  (i_load_k),
        .rise_o (load_k_rise_s)
    );

    conv_seq_fsm_gpio_edge_sync u_sync_next (
        .clk_i  (CLK100MHZ),
        .rst_ni (i_reset),
        .pin_i  (i_next),
        .rise_o (next_rise_s)
    );

    assign drain_end_s = CNT_W'(last_q) + CNT_LAT;

    // Sequencer FSM; every output is a register updated alongside the state.
    // eop stays high whenever no image sweep (RUN/DRAIN) is in progress.
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            sop_q        <= 1'b0;
            eop_q        <= 1'b1;
            chblk_q      <= 1'b0;
            valid_q      <= 1'b0;
            ki_q         <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            blk_q        <= '0;
            frame_done_q <= 1'b0;
            last_q       <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_k_rise_s) begin
                        state_q <= S_KLOAD;
                        ki_q    <= 1'b1;
                        valid_q <= 1'b1;
                        raddr_q <= '0;
                    end else if (start_rise_s) begin
                        state_q      <= S_RUN;
                        sop_q        <= 1'b1;
                        eop_q        <= 1'b0;
                        valid_q      <= 1'b1;
                        raddr_q      <= '0;
                        waddr_q      <= '0;
                        cnt_q        <= '0;
                        last_q       <= i_last_addr;
                        frame_done_q <= 1'b0;
                    end else if (next_rise_s) begin
                        state_q <= S_CHBLK;
                        chblk_q <= 1'b1;
                        if (blk_q == BLK_LAST) begin
                            blk_q        <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            blk_q <= blk_q + BLK_ONE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_KLOAD: begin
                    if (raddr_q == K_LAST) begin
                        state_q <= S_IDLE;
                        ki_q    <= 1'b0;
                        valid_q <= 1'b0;
                        raddr_q <= '0;
                    end else begin
                        raddr_q <= raddr_q + ADDR_ONE;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    // waddr is the read address W_LAT cycles ago, floored at zero.
                    if (cnt_q >= CNT_LAT) begin
                        waddr_q <= waddr_q + ADDR_ONE;
                    end
                    if (raddr_q == last_q) begin
                        state_q <= S_DRAIN;
                        valid_q <= 1'b0;
                    end else begin
                        raddr_q <= raddr_q + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == drain_end_s) begin
                        state_q <= S_IDLE;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b1;
                        raddr_q <= '0;
                        waddr_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q >= CNT_LAT) begin
                            waddr_q <= waddr_q + ADDR_ONE;
                        end
                    end
                end
                S_CHBLK: begin
                    state_q <= S_IDLE;
                    chblk_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    sop_q   <= 1'b0;
                    eop_q   <= 1'b1;
                    chblk_q <= 1'b0;
                    valid_q <= 1'b0;
                    ki_q    <= 1'b0;
                    raddr_q <= '0;
                    waddr_q <= '0;
                end
            endcase
        end
    end

    assign o_sop        = sop_q;
    assign o_eop        = eop_q;
    assign o_chblk      = chblk_q;
    assign o_valid      = valid_q;
    assign o_ki         = ki_q;
    assign o_raddr      = raddr_q;
    assign o_waddr      = waddr_q;
    assign o_blk        = blk_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_seq_fsm.sv
// Self-checking bench for conv_seq_fsm: sequence-level reference model plus directed literal checks.
module tb_conv_seq_fsm;

    localparam int NB   = 10;
    localparam int WL   = 3;
    localparam int KR   = 3;
    localparam int NBLK = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          load_k    = 1'b0;
    logic          nxt       = 1'b0;
    logic [NB-1:0] last_addr = '0;

    logic          o_sop, o_eop, o_chblk, o_valid, o_ki, o_frame_done;
    logic [NB-1:0] o_raddr, o_waddr;
    logic [1:0]    o_blk;

    conv_seq_fsm #(
        .NB_ADDRESS (NB),
        .W_LAT      (WL),
        .K_ROWS     (KR),
        .N_BLOCKS   (NBLK)
    ) dut (
        .CLK100MHZ    (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_load_k     (load_k),
        .i_next       (nxt),
        .i_last_addr  (last_addr),
        .o_sop        (o_sop),
        .o_eop        (o_eop),
        .o_chblk      (o_chblk),
        .o_valid      (o_valid),
        .o_ki         (o_ki),
        .o_raddr      (o_raddr),
        .o_waddr      (o_waddr),
        .o_blk        (o_blk),
        .o_frame_done (o_frame_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic          valid;
        logic          ki;
        logic          chblk;
        logic [NB-1:0] raddr;
        logic [NB-1:0] waddr;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     cur;
    bit       busy;
    int       m_blk;
    bit       m_done;
    logic [2:0] h_ld, h_st, h_nx;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e     = '0;
        e.eop = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur    = idle_rec();
        busy   = 1'b0;
        m_blk  = 0;
        m_done = 1'b0;
        h_ld   = '0;
        h_st   = '0;
        h_nx   = '0;
    endtask

    // At each edge: detect commands from the pin history (rise seen 3 edges late),
    // expand an accepted command into its whole expected output sequence, then advance.
    task automatic model_step();
        bit   ld_e, st_e, nx_e;
        int   last;
        exp_t e;
        ld_e = h_ld[1] & ~h_ld[2];
        st_e = h_st[1] & ~h_st[2];
        nx_e = h_nx[1] & ~h_nx[2];
        h_ld = {h_ld[1:0], load_k};
        h_st = {h_st[1:0], start};
        h_nx = {h_nx[1:0], nxt};
        if (!busy) begin
            if (ld_e) begin
                for (int i = 0; i < KR; i++) begin
                    e       = idle_rec();
                    e.ki    = 1'b1;
                    e.valid = 1'b1;
                    e.raddr = NB'(i);
                    exp_q.push_back(e);
                end
            end else if (st_e) begin
                last   = int'(last_addr);
                m_done = 1'b0;
                for (int k = 0; k <= last + WL; k++) begin
                    e       = '0;
                    e.sop   = 1'b1;
                    e.valid = (k <= last);
                    e.raddr = NB'((k <= last) ? k : last);
                    e.waddr = NB'((k > WL) ? k - WL : 0);
                    exp_q.push_back(e);
                end
            end else if (nx_e) begin
                e       = idle_rec();
                e.chblk = 1'b1;
                exp_q.push_back(e);
                m_blk = (m_blk + 1) % NBLK;
                if (m_blk == 0) m_done = 1'b1;
            end
        end
        if (exp_q.size() > 0) begin
            cur  = exp_q.pop_front();
            busy = 1'b1;
        end else begin
            cur  = idle_rec();
            busy = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("sop",   int'(o_sop),        int'(cur.sop));
            chk("eop",   int'(o_eop),        int'(cur.eop));
            chk("valid", int'(o_valid),      int'(cur.valid));
            chk("ki",    int'(o_ki),         int'(cur.ki));
            chk("chblk", int'(o_chblk),      int'(cur.chblk));
            chk("raddr", int'(o_raddr),      int'(cur.raddr));
            chk("waddr", int'(o_waddr),      int'(cur.waddr));
            chk("blk",   int'(o_blk),        m_blk);
            chk("done",  int'(o_frame_done), int'(m_done));
        end
    end

    // Raise the chosen pins for one cycle; returns on the sample point of the op's first cycle.
    task automatic cmd_pulse(input bit ld, input bit st, input bit nx);
        load_k = ld;
        start  = st;
        nxt    = nx;
        @(negedge clk);
        load_k = 1'b0;
        start  = 1'b0;
        nxt    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_eop", int'(o_eop), 1);
        chk("rst_sop", int'(o_sop), 0);
        chk("rst_raddr", int'(o_raddr), 0);

        cmd_pulse(1'b1, 1'b0, 1'b0);
        chk("kl_ki0", int'(o_ki), 1);
        chk("kl_raddr0", int'(o_raddr), 0);
        cyc(2);
        chk("kl_raddr2", int'(o_raddr), 2);
        chk("kl_valid2", int'(o_valid), 1);
        cyc(1);
        chk("kl_ki_end", int'(o_ki), 0);
        chk("kl_valid_end", int'(o_valid), 0);

        last_addr = NB'(9);
        cmd_pulse(1'b0, 1'b1, 1'b0);
        last_addr = NB'(3);
        chk("sw_sop0", int'(o_sop), 1);
        chk("sw_raddr0", int'(o_raddr), 0);
        cyc(3);
        chk("sw_waddr3", int'(o_waddr), 0);
        cyc(1);
        chk("sw_waddr4", int'(o_waddr), 1);
        cyc(5);
        chk("sw_raddr9", int'(o_raddr), 9);
        chk("sw_valid9", int'(o_valid), 1);
        cyc(3);
        chk("sw_drain_waddr", int'(o_waddr), 9);
        chk("sw_drain_valid", int'(o_valid), 0);
        chk("sw_drain_raddr", int'(o_raddr), 9);
        cyc(1);
        chk("sw_end_eop", int'(o_eop), 1);
        chk("sw_end_sop", int'(o_sop), 0);

        last_addr = NB'(20);
        cmd_pulse(1'b0, 1'b1, 1'b0);
        cyc(5);
        chk("mr_raddr5", int'(o_raddr), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_eop", int'(o_eop), 1);
        chk("mr_sop", int'(o_sop), 0);
        chk("mr_valid", int'(o_valid), 0);
        chk("mr_raddr", int'(o_raddr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        cmd_pulse(1'b1, 1'b1, 1'b0);
        chk("sim_ki", int'(o_ki), 1);
        chk("sim_sop", int'(o_sop), 0);
        cyc(11);
        chk("sim_no_replay", int'(o_sop), 0);

        last_addr = NB'(15);
        cmd_pulse(1'b0, 1'b1, 1'b0);
        cyc(2);
        nxt = 1'b1;
        cyc(1);
        nxt = 1'b0;
        cyc(20);
        cmd_pulse(1'b0, 1'b0, 1'b1);
        chk("nx_chblk", int'(o_chblk), 1);
        chk("nx_blk", int'(o_blk), 1);
        cyc(1);
        chk("nx_chblk_off", int'(o_chblk), 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            cmd_pulse(1'b0, 1'b0, 1'b1);
            chk("fr_blk", int'(o_blk), i % 4);
            @(negedge clk);
        end
        chk("fr_done", int'(o_frame_done), 1);
        last_addr = '0;
        cmd_pulse(1'b0, 1'b1, 1'b0);
        chk("fr_done_clr", int'(o_frame_done), 0);
        chk("l0_valid", int'(o_valid), 1);
        cyc(1);
        chk("l0_drain_valid", int'(o_valid), 0);
        chk("l0_drain_sop", int'(o_sop), 1);
        cyc(3);
        chk("l0_end_eop", int'(o_eop), 1);

        for (int it = 0; it < 50; it++) begin
            if (it == 20) begin
                cyc(40);
                last_addr = '1;
                start     = 1'b1;
            end else begin
                last_addr = ($urandom_range(0, 9) == 0) ? '0 : NB'($urandom_range(1, 30));
                load_k    = ($urandom_range(0, 3) == 0);
                start     = ($urandom_range(0, 1) == 1);
                nxt       = ($urandom_range(0, 1) == 1);
            end
            cyc($urandom_range(1, 3));
            load_k = 1'b0;
            start  = 1'b0;
            nxt    = 1'b0;
            if ($urandom_range(0, 3) == 0) last_addr = NB'($urandom_range(0, 30));
            if (it == 20) cyc(1040);
            else cyc($urandom_range(1, 45));
            if (it == 35) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        cyc(5);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
